adf4159_prog: RTL and testbench

- Serial programmer for one ADF4159 fractional-N PLL. Sits directly downstream of the top-level load sequencers; six instances run in parallel.
- On a load request it latches a 12-bit INT and a 25-bit FRAC value. It then shifts 32-bit register words MSB-first over a 3-wire interface (clk/data/LE).
- The first load after reset sends the full init sequence (R7..R0). Every later load sends only R1 then R0.
- It reports progress with a level busy and a one-cycle done.

---
 rtl/adf4159_pkg.sv | 31 +++
 rtl/spi_word_tx.sv | 62 ++++++
 rtl/adf4159_prog.sv | 92 +++++++++
 tb/tb_adf4159_prog.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/adf4159_pkg.sv
// adf4159_pkg: register constants, control codes and word builder for the ADF4159 programmer
package adf4159_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, FINISH} state_e;
  localparam logic [2:0] CTRL_R0 = 3'd0;
  localparam logic [2:0] CTRL_R1 = 3'd1;
  localparam logic [2:0] CTRL_R2 = 3'd2;
  localparam logic [2:0] CTRL_R3 = 3'd3;
  localparam logic [2:0] CTRL_R4 = 3'd4;
  localparam logic [2:0] CTRL_R5 = 3'd5;
  localparam logic [2:0] CTRL_R6 = 3'd6;
  localparam logic [2:0] CTRL_R7 = 3'd7;
  localparam logic [3:0] R0_MUXOUT = 4'b0110;
  localparam logic [31:0] R2_INIT = {29'h00E01001, CTRL_R2};
  localparam logic [31:0] R3_INIT = {29'h00086008, CTRL_R3};
  localparam logic [31:0] R4_INIT = {29'h00030020, CTRL_R4};
  localparam logic [31:0] R5_INIT = {29'h00009000, CTRL_R5};
  localparam logic [31:0] R6_INIT = {29'h00010000, CTRL_R6};
  localparam logic [31:0] R7_INIT = {29'h00000000, CTRL_R7};
  function automatic logic [31:0] reg_word(input logic [2:0] r, input logic [11:0] i, input logic [24:0] f);
    case (r)
      3'd0: reg_word = {1'b0, R0_MUXOUT, i, f[24:13], CTRL_R0};
      3'd1: reg_word = {4'b0000, f[12:0], 12'd0, CTRL_R1};
      3'd2: reg_word = R2_INIT;
      3'd3: reg_word = R3_INIT;
      3'd4: reg_word = R4_INIT;
      3'd5: reg_word = R5_INIT;
      3'd6: reg_word = R6_INIT;
      default: reg_word = R7_INIT;
    endcase
  endfunction
endpackage

// File: rtl/spi_word_tx.sv
// spi_word_tx: shifts one 32-bit word MSB-first with LE framing, pulses word_done on the last cycle
module spi_word_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] word,
  output logic        word_done,
  output logic        spi_clk,
  output logic        spi_data,
  output logic        spi_le
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic          active_q, active_d, ph_q, ph_d, last_div;
  logic [31:0]   sh_q, sh_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  always_comb begin
    last_div = div_q == DW'(CLK_DIV - 1);
    word_done = active_q && ph_q && last_div && bit_q == 5'd31;
    active_d = active_q;
    ph_d = ph_q;
    sh_d = sh_q;
    div_d = div_q;
    bit_d = bit_q;
    if (start) begin
      active_d = 1'b1;
      ph_d = 1'b0;
      sh_d = word;
      div_d = '0;
      bit_d = '0;
    end else if (active_q) begin
      div_d = last_div ? '0 : div_q + DW'(1);
      active_d = ~word_done;
      if (last_div) ph_d = ~ph_q;
      // the falling spi_clk edge presents the next bit
      if (last_div && ph_q && !word_done) begin
        bit_d = bit_q + 5'd1;
        sh_d = sh_q << 1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ph_q <= 1'b0;
      sh_q <= '0;
      div_q <= '0;
      bit_q <= '0;
    end else begin
      active_q <= active_d;
      ph_q <= ph_d;
      sh_q <= sh_d;
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end
  assign spi_clk = ph_q;
  assign spi_data = active_q & sh_q[31];
  assign spi_le = ~active_q;
endmodule

// File: rtl/adf4159_prog.sv
// adf4159_prog: sequences the R7..R0 init list or the R1,R0 update list into spi_word_tx
module adf4159_prog
  import adf4159_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LE_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] ints,
  input  logic [24:0] fracs,
  output logic        busy,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_data,
  output logic        spi_le
);
  localparam int GW = LE_GAP > 1 ? $clog2(LE_GAP) : 1;
  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d, nxt_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic          armed_q, armed_d, init_q, init_d;
  logic [11:0]   ints_q, ints_d;
  logic [24:0]   fracs_q, fracs_d;
  logic          accept, gap_end, start, word_done;
  logic [31:0]   word;
  always_comb begin
    accept = state_q == IDLE && load && armed_q;
    gap_end = state_q == GAP && gap_q == GW'(LE_GAP - 1);
    // idx_q holds the register number being sent; the list always ends at R0
    nxt_idx = accept ? (init_q ? 3'd1 : 3'd7) : idx_q - 3'd1;
    start = accept || (gap_end && idx_q != 3'd0);
    word = accept ? reg_word(nxt_idx, ints, fracs) : reg_word(nxt_idx, ints_q, fracs_q);
    idx_d = start ? nxt_idx : idx_q;
    state_d = state_q;
    gap_d = gap_q;
    armed_d = armed_q;
    init_d = init_q;
    ints_d = accept ? ints : ints_q;
    fracs_d = accept ? fracs : fracs_q;
    case (state_q)
      IDLE: begin
        armed_d = ~load;
        state_d = accept ? SHIFT : IDLE;
      end
      SHIFT: begin
        state_d = word_done ? GAP : SHIFT;
        gap_d = '0;
      end
      GAP: begin
        gap_d = gap_end ? gap_q : gap_q + GW'(1);
        state_d = !gap_end ? GAP : (idx_q == 3'd0 ? FINISH : SHIFT);
      end
      FINISH: begin
        init_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      gap_q <= '0;
      armed_q <= 1'b1;
      init_q <= 1'b0;
      ints_q <= '0;
      fracs_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      armed_q <= armed_d;
      init_q <= init_d;
      ints_q <= ints_d;
      fracs_q <= fracs_d;
    end
  end
  assign busy = state_q == SHIFT || state_q == GAP;
  assign done = state_q == FINISH;
  spi_word_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word(word),
    .word_done(word_done),
    .spi_clk(spi_clk),
    .spi_data(spi_data),
    .spi_le(spi_le)
  );
endmodule

// File: tb/tb_adf4159_prog.sv
// tb_adf4159_prog: table vectors, random loads and corner sequences against a word-list model
module tb_adf4159_prog;
  import adf4159_pkg::*;
  localparam int CD = 2;
  localparam int LG = 4;
  localparam int WCYC = 64 * CD + LG;
  typedef struct {
    logic [11:0] i;
    logic [24:0] f;
    bit          perturb;
    int          busy_cyc;
    logic [31:0] r1;
    logic [31:0] r0;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [11:0] ints = '0;
  logic [24:0] fracs = '0;
  logic busy, done, spi_clk, spi_data, spi_le;
  int checks = 0, errors = 0;
  bit model_init = 1'b0;
  int last_busy;
  logic [31:0] words[$];
  vec_t tv[4];

  adf4159_prog #(.CLK_DIV(CD), .LE_GAP(LG)) dut (
    .clk(clk), .rst(rst), .load(load), .ints(ints), .fracs(fracs),
    .busy(busy), .done(done), .spi_clk(spi_clk), .spi_data(spi_data), .spi_le(spi_le)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int r, input logic [11:0] i, input logic [24:0] f);
    if (r == 0) return {1'b0, 4'b0110, i, f[24:13], 3'b000};
    if (r == 1) return {4'b0000, f[12:0], 12'd0, 3'b001};
    if (r == 2) return R2_INIT;
    if (r == 3) return R3_INIT;
    if (r == 4) return R4_INIT;
    if (r == 5) return R5_INIT;
    if (r == 6) return R6_INIT;
    return R7_INIT;
  endfunction

  // decode each LE-low window into a word and check its bit timing
  initial begin
    logic pl, pc, pd, in_word;
    int lo_len, rises, viol;
    logic [31:0] sh;
    pl = 1'b1; pc = 1'b0; pd = 1'b0; in_word = 1'b0;
    lo_len = 0; rises = 0; viol = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) in_word = 1'b0;
      else begin
        if (pl && !spi_le) begin
          in_word = 1'b1; lo_len = 0; rises = 0; viol = 0; sh = '0;
        end
        if (in_word && !spi_le) begin
          lo_len++;
          if (spi_clk && !pc) begin rises++; sh = {sh[30:0], spi_data}; end
          if (spi_clk && pc && spi_data !== pd) viol++;
        end
        if (in_word && spi_le && !pl) begin
          words.push_back(sh);
          chk("le_low_len", lo_len, 64 * CD);
          chk("clk_rises", rises, 32);
          chk("data_stable", viol, 0);
          in_word = 1'b0;
        end
      end
      pl = spi_le; pc = spi_clk; pd = spi_data;
    end
  end

  task automatic do_txn(input logic [11:0] i, input logic [24:0] f, input bit hold, input bit perturb);
    int n, cnt, dn;
    n = model_init ? 2 : 8;
    words.delete();
    @(negedge clk);
    ints = i; fracs = f; load = 1'b1;
    chk("busy_pre", busy, 0);
    @(negedge clk);
    if (!hold) load = 1'b0;
    if (perturb) begin ints = 12'($urandom); fracs = 25'($urandom); end
    cnt = 0; dn = 0;
    while (busy && cnt < 5000) begin
      if (done) dn++;
      cnt++;
      if (perturb && cnt == 100) begin ints = 12'($urandom); fracs = 25'($urandom); end
      @(negedge clk);
    end
    last_busy = cnt;
    chk("busy_len", cnt, n * WCYC);
    chk("done_pulse", done, 1);
    chk("done_in_busy", dn, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("word_cnt", words.size(), n);
    for (int k = 0; k < n && k < words.size(); k++) chk($sformatf("word%0d", k), words[k], mdl_word(n - 1 - k, i, f));
    model_init = 1'b1;
  endtask

  initial begin
    int n, r, t;
    logic pc2;
    tv[0] = '{12'd44, 25'd31407723, 1'b0, 1056, 32'h0F358001, 32'h301677C8};
    tv[1] = '{12'd98, 25'd9702969, 1'b1, 264, 32'h071C8001, 32'h30312500};
    tv[2] = '{12'hFFF, 25'h1FFFFFF, 1'b0, 264, 32'h0FFF8001, 32'h37FFFFF8};
    tv[3] = '{12'd0, 25'd0, 1'b1, 264, 32'h00000001, 32'h30000000};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_spi_clk", spi_clk, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_spi_le", spi_le, 1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_txn(tv[k].i, tv[k].f, 1'b0, tv[k].perturb);
      chk("tbl_busy", last_busy, tv[k].busy_cyc);
      if (words.size() >= 2) begin
        chk("tbl_r1", words[words.size() - 2], tv[k].r1);
        chk("tbl_r0", words[words.size() - 1], tv[k].r0);
      end else chk("tbl_words", words.size(), 2);
    end
    // load held through completion must not retrigger
    do_txn(12'd77, 25'h0123456, 1'b1, 1'b0);
    n = 0;
    repeat (30) begin @(negedge clk); if (busy) n++; end
    chk("no_retrigger", n, 0);
    load = 1'b0;
    @(negedge clk);
    do_txn(12'd500, 25'h1555555, 1'b0, 1'b0);
    // reset in the middle of R1
    @(negedge clk);
    ints = 12'd321; fracs = 25'h0ABCDEF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    r = 0; t = 0; pc2 = spi_clk;
    while (r < 11 && t < 3000) begin
      @(negedge clk);
      if (spi_clk && !pc2) r++;
      pc2 = spi_clk;
      t++;
    end
    chk("rst_reach_bit", r, 11);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_le", spi_le, 1);
    chk("abort_clk", spi_clk, 0);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    model_init = 1'b0;
    do_txn(12'd1234, 25'h0F0F0F0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) do_txn(12'($urandom), 25'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
